// File: rtl/uart_tx_frame_module_if.sv
// Purpose: transmit-request / status bundle between upstream logic and the UART transmitter.
// Latency: none (wires only).
// Backpressure: upstream must watch TX_Busy; requests made while busy are dropped by the slave.
// Signals: TX_En_Sig/TX_Data (request, master -> slave); TX_Pin_Out/TX_Busy/TX_Done_Sig (slave -> master).
interface uart_tx_frame_module_if;
    logic       TX_En_Sig;
    logic [7:0] TX_Data;
    logic       TX_Pin_Out;
    logic       TX_Busy;
    logic       TX_Done_Sig;

    modport master (
        output TX_En_Sig, TX_Data,
        input  TX_Pin_Out, TX_Busy, TX_Done_Sig
    );

    modport slave (
        input  TX_En_Sig, TX_Data,
        output TX_Pin_Out, TX_Busy, TX_Done_Sig
    );
endinterface

// File: rtl/uart_tx_frame_module.sv
// Purpose: UART transmitter, one byte per request as 8N1 (start, D0..D7 LSB first, stop).
// Latency: line drops low on the accept edge; done pulses 10*BAUD_DIV clocks later (11 with parity).
// Backpressure: TX_Busy high from accept to done; requests seen while busy are dropped, never queued.
// Ports: CLK, RSTn (async active-low), bus (slave modport: TX_En_Sig, TX_Data in;
//        TX_Pin_Out, TX_Busy, TX_Done_Sig out, all outputs registered).
// Option: define UART_TX_PARITY_EN to insert an even-parity bit between D7 and the stop bit.
module uart_tx_frame_module #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int BAUD_DIV  = CLK_FREQ / BAUD_RATE
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    uart_tx_frame_module_if.slave  bus
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             pin_q, pin_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    // Parity is captured at accept time because the shift register is consumed during DATA.
    logic             par_q, par_d;
`endif

    assign bus.TX_Pin_Out  = pin_q;
    assign bus.TX_Busy     = busy_q;
    assign bus.TX_Done_Sig = done_q;

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            pin_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            pin_q   <= pin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pin_d   = pin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        // The counter free-runs through every bit cell so each cell is exactly BAUD_DIV clocks.
        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.TX_En_Sig) begin
                    shreg_d = bus.TX_Data;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^bus.TX_Data;
`endif
                    pin_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    pin_d   = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q != 3'd7) begin
                        idx_d   = idx_q + 3'd1;
                        pin_d   = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end else begin
`ifdef UART_TX_PARITY_EN
                        pin_d   = par_q;
                        state_d = PARITY;
`else
                        pin_d   = 1'b1;
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    pin_d   = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // A request on this edge is dropped: state is still STOP, not IDLE.
                if (bit_end) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_module.sv
// Purpose: directed bench for uart_tx_frame_module with a queue-based scoreboard and line monitor.
// Latency: frames decoded from mid-bit samples; done expected exactly one frame length after accept.
// Backpressure: requests issued while busy must not produce frames; honours UART_TX_PARITY_EN.
module tb_uart_tx_frame_module;

    localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * DIV;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         gap;   // expected clocks since previous done pulse; 0 = unchecked
    } exp_t;

    logic CLK;
    logic RSTn;
    uart_tx_frame_module_if bus ();

    uart_tx_frame_module #(.CLK_FREQ(1600), .BAUD_RATE(100)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   stray_done = 0;
    int   idle_bad = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic p, input int gap);
        exp_t e;
        e.data = d;
        e.par  = p;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge CLK);
        bus.TX_En_Sig = 1'b1;
        bus.TX_Data   = d;
        @(negedge CLK);
        bus.TX_En_Sig = 1'b0;
    endtask

    // Monitor: tracks each frame from the busy rising edge, samples mid-bit, checks done timing.
    initial begin
        logic        in_frame;
        logic        prev_busy;
        logic        busy_ok;
        logic [10:0] bits;
        int          off;
        int          last_done;
        exp_t        e;
        in_frame  = 1'b0;
        prev_busy = 1'b0;
        busy_ok   = 1'b1;
        bits      = '0;
        off       = 0;
        last_done = 0;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                in_frame  = 1'b0;
                prev_busy = 1'b0;
            end else begin
                if (!in_frame && bus.TX_Busy && !prev_busy) begin
                    in_frame = 1'b1;
                    off      = 0;
                    busy_ok  = 1'b1;
                    bits     = '0;
                end
                if (in_frame) begin
                    if (off < FRAME) begin
                        if (!bus.TX_Busy) busy_ok = 1'b0;
                        if (bus.TX_Done_Sig) stray_done++;
                        if (off % DIV == DIV / 2) bits[off / DIV] = bus.TX_Pin_Out;
                        off++;
                    end else begin
                        in_frame = 1'b0;
                        if (sb.size() == 0) begin
                            check("unexpected_frame", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            check("start_bit", int'(bits[0]), 0);
                            check("data_byte", int'(bits[8:1]), int'(e.data));
`ifdef UART_TX_PARITY_EN
                            check("parity_bit", int'(bits[9]), int'(e.par));
`endif
                            check("stop_bit", int'(bits[NB-1]), 1);
                            check("done_at_frame_end", int'(bus.TX_Done_Sig), 1);
                            check("busy_whole_frame", int'(busy_ok && !bus.TX_Busy), 1);
                            if (e.gap != 0) check("done_spacing", cyc - last_done, e.gap);
                        end
                        last_done = cyc;
                    end
                end else begin
                    if (bus.TX_Done_Sig) stray_done++;
                    if (!bus.TX_Busy && bus.TX_Pin_Out !== 1'b1) idle_bad++;
                end
                prev_busy = bus.TX_Busy;
            end
        end
    end

    initial begin
        RSTn          = 1'b0;
        bus.TX_En_Sig = 1'b0;
        bus.TX_Data   = 8'h00;
        repeat (3) @(negedge CLK);
        check("reset_pin", int'(bus.TX_Pin_Out), 1);
        check("reset_busy", int'(bus.TX_Busy), 0);
        check("reset_done", int'(bus.TX_Done_Sig), 0);
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);

        // Basic frame: A5 -> line 0,1,0,1,0,0,1,0,1,1
        push(8'hA5, 1'b0, 0);
        send(8'hA5);
        repeat (FRAME + 10) @(negedge CLK);

        // Busy rejection: FF requested ~clock 50 of a 3C frame must be dropped
        push(8'h3C, 1'b0, 0);
        send(8'h3C);
        repeat (48) @(negedge CLK);
        send(8'hFF);
        repeat (FRAME + 10) @(negedge CLK);

        // Back-to-back with enable held high: 00 then FF, done pulses FRAME+1 apart
        push(8'h00, 1'b0, 0);
        push(8'hFF, 1'b0, FRAME + 1);
        @(negedge CLK);
        bus.TX_En_Sig = 1'b1;
        bus.TX_Data   = 8'h00;
        repeat (2) @(negedge CLK);
        bus.TX_Data   = 8'hFF;
        repeat (FRAME + 40) @(negedge CLK);
        bus.TX_En_Sig = 1'b0;
        repeat (FRAME + 10) @(negedge CLK);

        // Mid-frame reset at clock 70 of a 55 frame (line is low there: D3=0)
        send(8'h55);
        repeat (69) @(negedge CLK);
        check("pre_reset_pin_low", int'(bus.TX_Pin_Out), 0);
        RSTn = 1'b0;
        #1;
        check("midreset_pin", int'(bus.TX_Pin_Out), 1);
        check("midreset_busy", int'(bus.TX_Busy), 0);
        check("midreset_done", int'(bus.TX_Done_Sig), 0);
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);
        push(8'h81, 1'b0, 0);
        send(8'h81);
        repeat (FRAME + 10) @(negedge CLK);

        // Data stability: TX_Data scrambled every clock during a 0F frame
        push(8'h0F, 1'b0, 0);
        send(8'h0F);
        for (int i = 0; i < FRAME; i++) begin
            bus.TX_Data = 8'($urandom);
            @(negedge CLK);
        end
        repeat (10) @(negedge CLK);

`ifdef UART_TX_PARITY_EN
        push(8'h07, 1'b1, 0);
        send(8'h07);
        repeat (FRAME + 10) @(negedge CLK);
        push(8'h03, 1'b0, 0);
        send(8'h03);
        repeat (FRAME + 10) @(negedge CLK);
`endif

        repeat (20) @(negedge CLK);
        check("frames_outstanding", sb.size(), 0);
        check("stray_done_pulses", stray_done, 0);
        check("idle_line_not_high", idle_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
